// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-way pipelined selector.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;
  // A select field is never narrower than one bit, even for tiny N.
  localparam int SEL_W_MIN     = 1;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width of the select field needed to address n channels.
  function automatic int sel_w(input int n);
    return (clog2(n) < SEL_W_MIN) ? SEL_W_MIN : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Bus bundle for mux_n_pipe: input channel handshake, flush, output handshake.
//
// Handshake rule for both sides: a word moves at a rising clk edge exactly
// when valid && ready are both high at that edge. A producer holding valid
// keeps its payload stable until the transfer; ready may change freely.
interface mux_n_pipe_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SEL_W = sel_w(N)
) ();

  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  // Upstream/downstream environment driving the block.
  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  // The selector block itself.
  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface

// File: rtl/mux_n_sel.sv
// Combinational N:1 WIDTH-bit selector. Out-of-range selects yield zero
// and raise oor.
module mux_n_sel #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   word,
  output logic               oor
);

  // Scan all channels; only a matching index overrides the zero default.
  always_comb begin
    word = '0;
    oor  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_data[k*WIDTH +: WIDTH];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way selector with a registered valid/ready output stage and flush.
// Build option MUX_N_PIPE_SKID_EN adds a one-word skid entry (capacity 2)
// so in_ready depends only on registered state; without it capacity is 1
// and in_ready follows out_ready combinationally.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SEL_W = sel_w(N)
) (
  input logic          clk,
  input logic          reset,
  mux_n_pipe_if.slave  bus
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_oor;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             sel_err_q;
  logic             accept;
  logic             out_free;

  mux_n_sel #(
    .WIDTH (WIDTH),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_sel (
    .in_data (bus.in_data),
    .sel     (bus.sel),
    .word    (sel_word),
    .oor     (sel_oor)
  );

  assign accept   = bus.in_valid && bus.in_ready;
  // Output register can take a new word: empty, or being emitted this edge.
  assign out_free = !out_valid_q || bus.out_ready;

`ifdef MUX_N_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_full_q;

  assign bus.in_ready = reset && !skid_full_q && !bus.flush;

  // Output register and skid: the skid always drains ahead of new input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (out_free) begin
      if (skid_full_q) begin
        out_data_q  <= skid_data_q;
        out_valid_q <= 1'b1;
        skid_full_q <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) out_data_q <= sel_word;
      end
    end else if (accept) begin
      skid_data_q <= sel_word;
      skid_full_q <= 1'b1;
    end
  end
`else
  assign bus.in_ready = reset && out_free && !bus.flush;

  // Single output register: load on accept whenever it is free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      out_valid_q <= accept;
      if (accept) out_data_q <= sel_word;
    end
  end
`endif

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-channel instance for streaming,
// backpressure and flush, and a 3-channel instance for out-of-range selects.
module tb_mux_n_pipe;

  localparam int W = 32;

  logic clk;
  logic reset;

  mux_n_pipe_if #(.WIDTH(W), .N(4), .SEL_W(2)) a ();
  mux_n_pipe_if #(.WIDTH(W), .N(3), .SEL_W(2)) b ();

  mux_n_pipe #(.WIDTH(W), .N(4), .SEL_W(2)) dut_a (.clk(clk), .reset(reset), .bus(a));
  mux_n_pipe #(.WIDTH(W), .N(3), .SEL_W(2)) dut_b (.clk(clk), .reset(reset), .bus(b));

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] ch_a[4];
  logic [W-1:0] ch_b[3];
  int tests;
  int fails;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop and compare whenever an output word is consumed.
  always @(negedge clk) begin
    if (reset && a.out_valid && a.out_ready) begin
      if (exp_a_q.size() == 0) check("out_a_unexpected", a.out_data, 'x);
      else check("out_a", a.out_data, exp_a_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset && b.out_valid && b.out_ready) begin
      if (exp_b_q.size() == 0) check("out_b_unexpected", b.out_data, 'x);
      else check("out_b", b.out_data, exp_b_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // Present one word on a; push its expectation when it is accepted.
  task automatic issue_a(input logic [1:0] s, input logic [W-1:0] exp);
    bit done;
    done = 0;
    a.in_valid = 1'b1;
    a.sel = s;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (a.in_ready) begin
        exp_a_q.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    a.in_valid = 1'b0;
    if (!done) check("accept_timeout_a", 0, 1);
  endtask

  task automatic issue_b(input logic [1:0] s, input logic [W-1:0] exp);
    bit done;
    done = 0;
    b.in_valid = 1'b1;
    b.sel = s;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (b.in_ready) begin
        exp_b_q.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    b.in_valid = 1'b0;
    if (!done) check("accept_timeout_b", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    ch_a = '{32'h11, 32'h22, 32'h33, 32'h44};
    ch_b = '{32'h11, 32'h22, 32'h33};
    reset = 1'b0;
    a.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    b.in_data = {32'h33, 32'h22, 32'h11};
    a.sel = '0; a.in_valid = 1'b0; a.flush = 1'b0; a.out_ready = 1'b0;
    b.sel = '0; b.in_valid = 1'b0; b.flush = 1'b0; b.out_ready = 1'b0;

    // Reset held for two cycles.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", a.in_ready, 0);
    check("rst_out_valid", a.out_valid, 0);
    check("rst_out_data", a.out_data, 0);
    check("rst_sel_err_a", a.sel_err, 0);
    check("rst_sel_err_b", b.sel_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", a.in_ready, 1);
    @(posedge clk); #1;

    // Streaming, no bubbles.
    a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a.in_valid = 1'b1;
      a.sel = 2'(i);
      @(negedge clk);
      check("stream_in_ready", a.in_ready, 1);
      if (i > 0) check("stream_out_valid", a.out_valid, 1);
      if (a.in_ready) exp_a_q.push_back(ch_a[i]);
      @(posedge clk); #1;
    end
    a.in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", a.out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_drained", a.out_valid, 0);
    @(posedge clk); #1;

    // Backpressure.
    a.out_ready = 1'b0;
    issue_a(2'd1, ch_a[1]);
`ifdef MUX_N_PIPE_SKID_EN
    issue_a(2'd2, ch_a[2]);
    @(negedge clk);
    check("bp_full_in_ready", a.in_ready, 0);
    check("bp_hold_data", a.out_data, ch_a[1]);
    check("bp_hold_valid", a.out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold_data2", a.out_data, ch_a[1]);
    @(posedge clk); #1;
    a.out_ready = 1'b1;
    idle(1);
    @(negedge clk);
    check("bp_ready_back", a.in_ready, 1);
    @(posedge clk); #1;
`else
    @(negedge clk);
    check("bp_held_in_ready", a.in_ready, 0);
    check("bp_hold_data", a.out_data, ch_a[1]);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold_data2", a.out_data, ch_a[1]);
    @(posedge clk); #1;
    a.in_valid = 1'b1;
    a.sel = 2'd2;
    a.out_ready = 1'b1;
    @(negedge clk);
    check("bp_comb_in_ready", a.in_ready, 1);
    if (a.in_ready) exp_a_q.push_back(ch_a[2]);
    @(posedge clk); #1;
    a.in_valid = 1'b0;
`endif
    idle(3);
    check("bp_drain_a", 32'(exp_a_q.size()), 0);

    // Flush with held words.
    a.out_ready = 1'b0;
    issue_a(2'd0, ch_a[0]);
`ifdef MUX_N_PIPE_SKID_EN
    issue_a(2'd3, ch_a[3]);
`endif
    a.in_valid = 1'b1;
    a.sel = 2'd2;
    a.flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", a.in_ready, 0);
    @(posedge clk); #1;
    a.flush = 1'b0;
    a.in_valid = 1'b0;
    exp_a_q.delete();
    @(negedge clk);
    check("flush_out_valid", a.out_valid, 0);
    check("flush_in_ready_after", a.in_ready, 1);
    check("flush_keeps_data", a.out_data, ch_a[0]);
    @(posedge clk); #1;
    a.out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("flush_nothing_left", a.out_valid, 0);
    @(posedge clk); #1;

    // Out-of-range select on the 3-channel instance.
    b.out_ready = 1'b1;
    issue_b(2'd3, 32'h0);
    @(negedge clk);
    check("oor_sel_err", b.sel_err, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) issue_b(2'(i % 3), ch_b[i % 3]);
    idle(3);
    @(negedge clk);
    check("oor_sel_err_sticky", b.sel_err, 1);
    check("in_range_no_err_a", a.sel_err, 0);
    check("drain_a", 32'(exp_a_q.size()), 0);
    check("drain_b", 32'(exp_b_q.size()), 0);
    @(posedge clk); #1;

    // Reset clears the sticky flag.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_clears_sel_err", b.sel_err, 0);
    check("rst_clears_valid", b.out_valid, 0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
